conv3x3_mac: RTL and testbench

- Streaming 3x3 convolution engine directly downstream of the 3x3 sliding-window stage.
- Consumes one 3x3 pixel window per valid cycle and produces one output feature pixel per window.
- Pipelined multiply–add with bias, arithmetic right shift and saturation.
- Owns a 9-tap weight register file plus bias, loaded only between frames, and a frame-output counter that flags end of frame to the pooling and FC stages.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_adder_tree.sv | 17 +
 rtl/conv3x3_mac.sv | 114 +++++++++++
 tb/tb_conv3x3_mac.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, FSM state type and width/saturation helpers for conv3x3_mac.
// Saturation limits depend on CONV_RELU_EN (unsigned ReLU range when defined, signed otherwise).
package conv_pkg;
    localparam int TAPS = 9;
    localparam logic [3:0] BIAS_ADDR = 4'd9;
    typedef enum logic {IDLE, RUN} state_e;
    function automatic int prod_width(input int pix_w, input int wgt_w);
        return pix_w + wgt_w + 1;
    endfunction
    function automatic longint sat_hi(input int out_w);
`ifdef CONV_RELU_EN
        return (longint'(1) << out_w) - 1;
`else
        return (longint'(1) << (out_w - 1)) - 1;
`endif
    endfunction
    function automatic longint sat_lo(input int out_w);
`ifdef CONV_RELU_EN
        return 0;
`else
        return -(longint'(1) << (out_w - 1));
`endif
    endfunction
endpackage

// File: rtl/conv_adder_tree.sv
// conv_adder_tree: combinational sum of TAPS signed products plus bias, sign-extended to ACC_W.
module conv_adder_tree
    import conv_pkg::*;
#(
    parameter int PROD_W = 17,
    parameter int ACC_W  = 24
)(
    input  logic [TAPS*PROD_W-1:0]  prods_i,
    input  logic signed [ACC_W-1:0] bias_i,
    output logic signed [ACC_W-1:0] sum_o
);
    always_comb begin
        sum_o = bias_i;
        for (int k = 0; k < TAPS; k++)
            sum_o = sum_o + ACC_W'($signed(prods_i[k*PROD_W +: PROD_W]));
    end
endmodule

// File: rtl/conv3x3_mac.sv
// conv3x3_mac: 3-stage streaming 3x3 MAC (multiply, add+bias, shift+saturate) with frame counter.
// CONV_RELU_EN selects unsigned ReLU output; otherwise output is signed saturated.
module conv3x3_mac
    import conv_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int PIX_W = 8,
    parameter int WGT_W = 8,
    parameter int ACC_W = 24,
    parameter int OUT_W = 8,
    parameter int SHIFT = 4
)(
    input  logic               iClk,
    input  logic               iRsn,
    input  logic [3*PIX_W-1:0] iWindowRow1,
    input  logic [3*PIX_W-1:0] iWindowRow2,
    input  logic [3*PIX_W-1:0] iWindowRow3,
    input  logic               iWindowValid,
    input  logic               iWgtWe,
    input  logic [3:0]         iWgtAddr,
    input  logic [ACC_W-1:0]   iWgtData,
    output logic [OUT_W-1:0]   oConvOut,
    output logic               oConvValid,
    output logic               oFrameDone,
    output logic               oBusy,
    output logic               oWgtErr
);
    localparam int PROD_W  = prod_width(PIX_W, WGT_W);
    localparam int FRAME_N = (IMG_W - 2) * (IMG_W - 2);
    localparam int CNT_W   = $clog2(FRAME_N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_N - 1);
    localparam logic signed [ACC_W-1:0] HI = ACC_W'(sat_hi(OUT_W));
    localparam logic signed [ACC_W-1:0] LO = ACC_W'(sat_lo(OUT_W));

    state_e state_q, state_d;
    logic signed [WGT_W-1:0]  wgt_q [TAPS];
    logic signed [ACC_W-1:0]  bias_q;
    logic [PIX_W-1:0]         pix [TAPS];
    logic signed [PROD_W-1:0] prod_q [TAPS];
    logic [TAPS*PROD_W-1:0]   prods;
    logic signed [ACC_W-1:0]  sum, sum_q, sh;
    logic [OUT_W-1:0]         out_q, out_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic v1_q, v2_q, vld_q, done_q, done_d, err_q, wr_ok;

    genvar g;
    for (g = 0; g < TAPS; g++) begin : g_tap
        assign pix[g] = PIX_W'((g < 3 ? iWindowRow1 : g < 6 ? iWindowRow2 : iWindowRow3) >> ((2 - g % 3) * PIX_W));
        assign prods[g*PROD_W +: PROD_W] = prod_q[g];
    end

    conv_adder_tree #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_tree (
        .prods_i(prods),
        .bias_i (bias_q),
        .sum_o  (sum)
    );

    assign oBusy = state_q == RUN || iWindowValid;
    assign wr_ok = iWgtWe && !oBusy && iWgtAddr <= BIAS_ADDR;
    assign sh    = sum_q >>> SHIFT;

    // Stay in RUN if the next frame has already entered the pipeline when the last result leaves.
    always_comb begin
        out_d   = sh > HI ? HI[OUT_W-1:0] : sh < LO ? LO[OUT_W-1:0] : sh[OUT_W-1:0];
        done_d  = v2_q && cnt_q == LAST;
        cnt_d   = v2_q ? (cnt_q == LAST ? '0 : cnt_q + 1'b1) : cnt_q;
        state_d = state_q == IDLE ? (iWindowValid ? RUN : IDLE)
                : (done_q && !iWindowValid && !v1_q && !v2_q ? IDLE : RUN);
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            state_q <= IDLE;
            bias_q  <= '0;
            for (int k = 0; k < TAPS; k++) begin
                wgt_q[k]  <= '0;
                prod_q[k] <= '0;
            end
            sum_q  <= '0;
            out_q  <= '0;
            cnt_q  <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wr_ok && iWgtAddr == BIAS_ADDR)
                bias_q <= iWgtData;
            for (int k = 0; k < TAPS; k++) begin
                if (wr_ok && iWgtAddr == 4'(k))
                    wgt_q[k] <= iWgtData[WGT_W-1:0];
                if (iWindowValid)
                    prod_q[k] <= $signed({1'b0, pix[k]}) * wgt_q[k];
            end
            if (v1_q)
                sum_q <= sum;
            if (v2_q)
                out_q <= out_d;
            v1_q   <= iWindowValid;
            v2_q   <= v1_q;
            vld_q  <= v2_q;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            err_q  <= err_q || (iWgtWe && !wr_ok);
        end
    end

    assign oConvOut   = out_q;
    assign oConvValid = vld_q;
    assign oFrameDone = done_q;
    assign oWgtErr    = err_q;
endmodule

// File: tb/tb_conv3x3_mac.sv
// tb_conv3x3_mac: directed vectors with a scoreboard queue; expectations assume SHIFT = 4.
module tb_conv3x3_mac;
    typedef struct packed {logic [7:0] v; logic d;} exp_t;

`ifdef CONV_RELU_EN
    localparam logic [7:0] E_NEG255 = 8'h00, E_NEG1 = 8'h00, E_POS255 = 8'hFF, E_POS2 = 8'h8E, E_BIGNEG = 8'h00;
`else
    localparam logic [7:0] E_NEG255 = 8'h80, E_NEG1 = 8'hFF, E_POS255 = 8'h7F, E_POS2 = 8'h7F, E_BIGNEG = 8'h80;
`endif

    logic clk = 1'b0;
    logic rsn = 1'b1;
    logic [23:0] row1 = '0, row2 = '0, row3 = '0, wdata = '0;
    logic win_v = 1'b0, we = 1'b0;
    logic [3:0] waddr = '0;
    logic [7:0] conv_out;
    logic conv_v, frame_done, busy, wgt_err;

    exp_t sb[$];
    exp_t mon_e;
    int n_vec = 0, n_err = 0, stray;

    always #5 clk = ~clk;

    conv3x3_mac dut (
        .iClk(clk), .iRsn(rsn),
        .iWindowRow1(row1), .iWindowRow2(row2), .iWindowRow3(row3), .iWindowValid(win_v),
        .iWgtWe(we), .iWgtAddr(waddr), .iWgtData(wdata),
        .oConvOut(conv_out), .oConvValid(conv_v), .oFrameDone(frame_done),
        .oBusy(busy), .oWgtErr(wgt_err)
    );

    function automatic logic [23:0] r(input logic [7:0] a, b, c);
        return {a, b, c};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send(input logic [23:0] a, b, c, input logic [7:0] e, input logic d, input bit push = 1'b1);
        @(posedge clk); #1;
        row1 = a; row2 = b; row3 = c; win_v = 1'b1; we = 1'b0;
        if (push) sb.push_back('{v: e, d: d});
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        win_v = 1'b0; we = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [23:0] d);
        @(posedge clk); #1;
        win_v = 1'b0; we = 1'b1; waddr = a; wdata = d;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic load_all(input logic [23:0] w, input logic [23:0] b);
        for (int k = 0; k < 9; k++) wr(4'(k), w);
        wr(4'd9, b);
    endtask

    task automatic drain;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout pending %0d expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic reset_dut;
        @(posedge clk); #1;
        rsn = 1'b0; win_v = 1'b0; we = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rsn = 1'b1;
    endtask

    task automatic full_frame(input logic [7:0] p, input logic [7:0] e);
        for (int i = 0; i < 676; i++) send(r(p, p, p), r(p, p, p), r(p, p, p), e, i == 675);
        idle(1);
        check("busy_in_run", 32'(busy), 1);
        drain;
        check("busy_after_frame", 32'(busy), 0);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (conv_v) begin
                    n_vec++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_out got %0h expected none", conv_out);
                    end else begin
                        mon_e = sb.pop_front();
                        if (conv_out !== mon_e.v || frame_done !== mon_e.d) begin
                            n_err++;
                            $display("FAIL out got %0h done %0b expected %0h done %0b", conv_out, frame_done, mon_e.v, mon_e.d);
                        end
                    end
                end else if (frame_done) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL stray_done got 1 expected 0");
                end
            end
        join_none

        #2 rsn = 1'b0;
        #10;
        check("rst_out", 32'(conv_out), 0);
        check("rst_valid", 32'(conv_v), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(wgt_err), 0);
        @(posedge clk); #1 rsn = 1'b1;

        // all taps 1, pixels 10: 90 >>> 4 = 5, full frame
        load_all(24'd1, 24'd0);
        full_frame(8'd10, 8'd5);

        // center tap only: 200 -> 12, 255 -> 15, center 0 -> 0, with a bubble
        reset_dut;
        wr(4'd4, 24'd1);
        send(r(77, 77, 77), r(33, 200, 99), r(77, 77, 77), 8'd12, 1'b0);
        send(r(1, 2, 3), r(4, 255, 6), r(7, 8, 9), 8'd15, 1'b0);
        idle(2);
        send(r(255, 255, 255), r(255, 0, 255), r(255, 255, 255), 8'd0, 1'b0);
        idle(1);
        check("busy_hold_run", 32'(busy), 1);
        drain;

        // all taps -1
        reset_dut;
        load_all(24'hFFFFFF, 24'd0);
        send(r(255, 255, 255), r(255, 255, 255), r(255, 255, 255), E_NEG255, 1'b0);
        send(r(1, 1, 1), r(1, 1, 1), r(1, 1, 1), E_NEG1, 1'b0);
        send(r(0, 0, 0), r(0, 0, 0), r(0, 0, 0), 8'd0, 1'b0);
        idle(1);
        drain;

        // all taps 127, plus a write while running that must be dropped
        reset_dut;
        load_all(24'd127, 24'd0);
        send(r(255, 255, 255), r(255, 255, 255), r(255, 255, 255), E_POS255, 1'b0);
        send(r(2, 2, 2), r(2, 2, 2), r(2, 2, 2), E_POS2, 1'b0);
        send(r(1, 1, 1), r(1, 1, 1), r(1, 1, 1), 8'h47, 1'b0);
        idle(1);
        check("err_before_run_write", 32'(wgt_err), 0);
        wr(4'd4, 24'd0);
        check("err_run_write", 32'(wgt_err), 1);
        send(r(1, 1, 1), r(1, 1, 1), r(1, 1, 1), 8'h47, 1'b0);
        idle(3);
        check("err_sticky", 32'(wgt_err), 1);
        drain;

        // bias only: 1600 >>> 4 = 100
        reset_dut;
        check("err_cleared_by_rst", 32'(wgt_err), 0);
        wr(4'd9, 24'd1600);
        send(r(9, 8, 7), r(6, 5, 4), r(3, 2, 1), 8'd100, 1'b0);
        idle(1);
        drain;

        // tap order: tap 0 is top-left (MSB slice), tap 8 is bottom-right
        reset_dut;
        wr(4'd0, 24'd16);
        wr(4'd8, 24'hFFFFF0);
        send(r(100, 7, 9), r(1, 2, 3), r(4, 5, 30), 8'd70, 1'b0);
        send(r(0, 7, 9), r(1, 2, 3), r(4, 5, 200), E_BIGNEG, 1'b0);
        idle(1);
        drain;

        // reserved address
        reset_dut;
        wr(4'd12, 24'd5);
        check("err_reserved_addr", 32'(wgt_err), 1);

        // write coinciding with a window is dropped (weights stay 0)
        reset_dut;
        @(posedge clk); #1;
        row1 = r(50, 50, 50); row2 = r(50, 50, 50); row3 = r(50, 50, 50);
        win_v = 1'b1; we = 1'b1; waddr = 4'd4; wdata = 24'd1;
        sb.push_back('{v: 8'd0, d: 1'b0});
        @(posedge clk); #1;
        win_v = 1'b0; we = 1'b0;
        check("err_write_with_window", 32'(wgt_err), 1);
        drain;

        // reset with windows in flight, then a fresh full frame
        reset_dut;
        load_all(24'd1, 24'd0);
        for (int i = 0; i < 3; i++) send(r(10, 10, 10), r(10, 10, 10), r(10, 10, 10), 8'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rsn = 1'b0; win_v = 1'b0;
        #1;
        check("midrst_out", 32'(conv_out), 0);
        check("midrst_valid", 32'(conv_v), 0);
        check("midrst_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #1 rsn = 1'b1;
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (conv_v) stray++;
        end
        check("midrst_no_valid", 32'(stray), 0);
        load_all(24'd1, 24'd0);
        full_frame(8'd20, 8'd11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
